onewire_master: RTL

- Parametrised successor of the single-line 1-Wire master.
- Adds N independent bus lines behind one channel selector, selectable normal/overdrive timing with separate dividers, real line sampling through a synchroniser, and a maskable completion interrupt.
- Sits between the Avalon-MM CPU bus and external open-drain pads.
- Software issues one bit or reset cycle at a time and polls or waits for the interrupt.

---
 rtl/onewire_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/onewire_master.sv
// Multi-line 1-Wire master behind an Avalon-MM slave. Software starts one data
// bit or one reset/presence cycle at a time on the selected line.
module onewire_master #(
    parameter int OWN   = 1,
    parameter int CDR_N = 375,
    parameter int CDR_O = 50,
    parameter int OWW   = (OWN > 1 ? $clog2(OWN) : 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            avalon_address,
    input  logic            avalon_read,
    input  logic            avalon_write,
    input  logic [31:0]     avalon_writedata,
    output logic [31:0]     avalon_readdata,
    output logic            avalon_waitrequest,
    output logic            avalon_interrupt,
    output logic [OWN-1:0]  onewire_oe,
    input  logic [OWN-1:0]  onewire_i
);

    localparam int DMAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
    localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam logic [DW-1:0] DN_LAST = DW'(CDR_N - 1);
    localparam logic [DW-1:0] DO_LAST = DW'(CDR_O - 1);

    logic           dtx_q, dtx_d;
    logic           rst_c_q, rst_c_d;
    logic           ovd_q, ovd_d;
    logic [OWW-1:0] sel_q, sel_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           drx_q, drx_d;
    logic           ien_q, ien_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [DW-1:0]  div_q, div_d;
    logic [OWN-1:0] oe_q, oe_d;
    logic [OWN-1:0] sync1_q, sync2_q;

    logic           ctl_wr_s, ctl_rd_s, ien_wr_s;
    logic [OWW-1:0] wr_sel_s;
    logic [OWN-1:0] wr_hot_s;
    logic           line_s;
    logic [DW-1:0]  div_last_s;
    logic           tick_s, rel_s, smp_s, end_s;

    assign ctl_wr_s   = avalon_write && (avalon_address == 1'b0) && !busy_q;
    assign ien_wr_s   = avalon_write && (avalon_address == 1'b1);
    assign ctl_rd_s   = avalon_read && (avalon_address == 1'b0);
    assign wr_sel_s   = avalon_writedata[OWW+7:8];
    assign div_last_s = ovd_q ? DO_LAST : DN_LAST;
    assign tick_s     = busy_q && (div_q == div_last_s);

    // One-hot drive pattern for the newly written selector and the synchronised
    // level of the active line; an out-of-range selector drives nothing and reads 1.
    always_comb begin
        wr_hot_s = '0;
        line_s   = 1'b1;
        for (int i = 0; i < OWN; i++) begin
            if (wr_sel_s == OWW'(i)) begin
                wr_hot_s[i] = 1'b1;
            end else begin
                wr_hot_s[i] = 1'b0;
            end
            if (sel_q == OWW'(i)) begin
                line_s = sync2_q[i];
            end else begin
                line_s = line_s;
            end
        end
    end

    // Tick-indexed release, sample and end points for data and reset cycles.
    always_comb begin
        if (rst_c_q) begin
            rel_s = tick_s && (cnt_q == 7'd63);
            smp_s = tick_s && (cnt_q == 7'd71);
            end_s = tick_s && (cnt_q == 7'd127);
        end else begin
            rel_s = tick_s && (dtx_q ? (cnt_q == 7'd0) : (cnt_q == 7'd6));
            smp_s = tick_s && (cnt_q == 7'd1);
            end_s = tick_s && (cnt_q == 7'd7);
        end
    end

    // Next-state logic for control, status and bit-timing registers.
    always_comb begin
        dtx_d   = dtx_q;
        rst_c_d = rst_c_q;
        ovd_d   = ovd_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        done_d  = done_q;
        drx_d   = drx_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        oe_d    = oe_q;
        if (ien_wr_s) begin
            ien_d = avalon_writedata[0];
        end else begin
            ien_d = ien_q;
        end
        if (ctl_rd_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
        if (ctl_wr_s) begin
            dtx_d   = avalon_writedata[0];
            rst_c_d = avalon_writedata[1];
            ovd_d   = avalon_writedata[2];
            sel_d   = wr_sel_s;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            cnt_d   = 7'd0;
            div_d   = '0;
            oe_d    = wr_hot_s;
        end else if (busy_q) begin
            div_d = tick_s ? '0 : div_q + DW'(1);
            cnt_d = tick_s ? cnt_q + 7'd1 : cnt_q;
            if (rel_s) begin
                oe_d = '0;
            end else begin
                oe_d = oe_q;
            end
            if (smp_s) begin
                drx_d = line_s;
            end else begin
                drx_d = drx_q;
            end
            // Completion beats a coincident CTL read so the event is never lost.
            if (end_s) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = 7'd0;
                oe_d   = '0;
            end else begin
                busy_d = busy_q;
            end
        end else begin
            div_d = '0;
        end
    end

    // State registers; reset releases every line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dtx_q   <= 1'b0;
            rst_c_q <= 1'b0;
            ovd_q   <= 1'b0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drx_q   <= 1'b0;
            ien_q   <= 1'b0;
            cnt_q   <= 7'd0;
            div_q   <= '0;
            oe_q    <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            dtx_q   <= dtx_d;
            rst_c_q <= rst_c_d;
            ovd_q   <= ovd_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drx_q   <= drx_d;
            ien_q   <= ien_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            oe_q    <= oe_d;
            sync1_q <= onewire_i;
            sync2_q <= sync1_q;
        end
    end

    // Register read mux.
    always_comb begin
        avalon_readdata = 32'd0;
        case (avalon_address)
            1'b0: begin
                avalon_readdata[0]       = drx_q;
                avalon_readdata[1]       = rst_c_q;
                avalon_readdata[2]       = ovd_q;
                avalon_readdata[3]       = busy_q;
                avalon_readdata[4]       = done_q;
                avalon_readdata[OWW+7:8] = sel_q;
            end
            1'b1: avalon_readdata[0] = ien_q;
            default: avalon_readdata = 32'd0;
        endcase
    end

    assign avalon_waitrequest = 1'b0;
    assign avalon_interrupt   = done_q & ien_q;
    assign onewire_oe         = oe_q;

endmodule
